// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the PC and feeds decode through a registered IF/ID slot.
module fetch_unit #(
    parameter int PC_WIDTH         = 32,
    parameter int RESET_PC         = 0,
    parameter int NUM_INSTRUCTIONS = 11
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    output logic [PC_WIDTH-1:0] o_pc,
    input  logic [31:0]         i_instruction,
    input  logic                i_redirect,
    input  logic [PC_WIDTH-1:0] i_redirect_pc,
    output logic                o_inst_valid,
    output logic [31:0]         o_inst,
    output logic [PC_WIDTH-1:0] o_inst_pc,
    input  logic                i_inst_ready,
    output logic                o_halted
);
    typedef enum logic {RUN, HALT} state_t;
    localparam logic [PC_WIDTH-1:0] LP_NUM   = PC_WIDTH'(NUM_INSTRUCTIONS);
    localparam logic [PC_WIDTH-1:0] LP_RESET = PC_WIDTH'(RESET_PC);
    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_inst_pc;
    logic [31:0]         r_inst;
    logic                r_inst_valid;
    logic                w_in_range;
    logic                w_xfer;
    logic                w_load;
    assign w_in_range = r_pc < LP_NUM;
    assign w_xfer     = r_inst_valid && i_inst_ready;
    assign w_load     = (r_state == RUN) && w_in_range && (!r_inst_valid || i_inst_ready) && !i_redirect;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= RUN;
            r_pc         <= LP_RESET;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else if (i_redirect) begin
            r_state      <= RUN;
            r_pc         <= i_redirect_pc;
            r_inst_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_inst       <= i_instruction;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
                r_pc         <= r_pc + PC_WIDTH'(1);
            end else if (w_xfer) begin
                r_inst_valid <= 1'b0;
            end
            // running off the end of the program parks the PC until a redirect
            if (r_state == RUN && !w_in_range) r_state <= HALT;
        end
    end
    assign o_pc         = r_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_halted     = (r_state == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed bench; a monitor scores every decode transfer against the expected program-order stream.
module tb_fetch_unit;
    localparam int NUM = 11;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] i_instruction;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready = 1'b0;
    logic        o_halted;
    logic [31:0] mem [16];
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(.PC_WIDTH(32), .RESET_PC(0), .NUM_INSTRUCTIONS(NUM)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_pc(o_pc), .i_instruction(i_instruction),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_inst_valid(o_inst_valid),
        .o_inst(o_inst), .o_inst_pc(o_inst_pc), .i_inst_ready(i_inst_ready), .o_halted(o_halted)
    );

    always #5 clk = ~clk;
    assign i_instruction = (o_pc < NUM) ? mem[o_pc[3:0]] : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // the stream decode should see from a given PC onward: every in-range word, in order
    task automatic restart_stream(input int t);
        exp_q.delete();
        for (int k = t; k < NUM; k++) exp_q.push_back({32'(k), mem[k]});
    endtask

    always @(negedge clk) begin
        if (rst_n && o_inst_valid && i_inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got pc %0h inst %0h expected none", o_inst_pc, o_inst);
            end else begin
                chk("xfer_pc_inst", {o_inst_pc, o_inst}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // caller sits just after an edge; this spans exactly one redirect edge
    task automatic redirect(input int t);
        i_redirect = 1'b1;
        i_redirect_pc = 32'(t);
        @(negedge clk);
        #1;
        restart_stream(t);
        tick();
        i_redirect = 1'b0;
        chk("redir_valid", 64'(o_inst_valid), 64'd0);
        chk("redir_pc", 64'(o_pc), 64'(t));
        chk("redir_halted", 64'(o_halted), 64'd0);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!o_halted && n < 60) begin
            tick();
            n++;
        end
        chk("halt_reached", 64'(o_halted), 64'd1);
    endtask

    task automatic wait_pc(input int p);
        int n = 0;
        while (!(o_inst_valid && o_inst_pc == 32'(p)) && n < 40) begin
            tick();
            n++;
        end
        chk("wait_pc", {31'd0, o_inst_valid, o_inst_pc}, {31'd0, 1'b1, 32'(p)});
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        #2;
        chk("rst_pc", 64'(o_pc), 64'd0);
        chk("rst_valid", 64'(o_inst_valid), 64'd0);
        chk("rst_inst", {o_inst_pc, o_inst}, 64'd0);
        chk("rst_halted", 64'(o_halted), 64'd0);
        restart_stream(0);
        i_inst_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            tick();
            chk("stream", {31'd0, o_inst_valid, o_inst_pc}, {31'd0, 1'b1, 32'(k)});
        end
        tick();
        chk("end_halted", 64'(o_halted), 64'd1);
        chk("end_valid", 64'(o_inst_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_pc_hold", 64'(o_pc), 64'd11);
        end
        redirect(2);
        tick();
        chk("halt_redir_pc", {31'd0, o_inst_valid, o_inst_pc}, {31'd0, 1'b1, 32'd2});
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_pc", 64'(o_pc), 64'd0);
        chk("async_valid", 64'(o_inst_valid), 64'd0);
        chk("async_halted", 64'(o_halted), 64'd0);
        restart_stream(0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("first_after_rst", {31'd0, o_inst_valid, o_inst_pc}, {31'd0, 1'b1, 32'd0});
        wait_pc(3);
        i_inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_inst", {o_inst_pc, o_inst}, {32'd3, mem[3]});
            chk("stall_pc", 64'(o_pc), 64'd4);
        end
        i_inst_ready = 1'b1;
        tick();
        chk("unstall", 64'(o_inst_pc), 64'd4);
        redirect(0);
        wait_pc(2);
        redirect(7);
        tick();
        chk("redir7", {o_inst_pc, o_inst}, {32'd7, mem[7]});
        wait_halt();
        redirect(20);
        tick();
        chk("oor_halt", 64'(o_halted), 64'd1);
        i_inst_ready = 1'b0;
        redirect(0);
        tick();
        chk("stall_fill", {31'd0, o_inst_valid, o_inst_pc}, {31'd0, 1'b1, 32'd0});
        redirect(5);
        tick();
        chk("stall_redir", {31'd0, o_inst_valid, o_inst_pc}, {31'd0, 1'b1, 32'd5});
        for (int c = 0; c < 400; c++) begin
            i_inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) redirect($urandom_range(0, 14));
            else tick();
        end
        i_inst_ready = 1'b1;
        wait_halt();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `IMem`. It owns the program counter, drives the word-indexed fetch address into `IMem`, and captures the returned instruction into an IF/ID output register. The output register presents the instruction to decode over a valid/ready handshake. The stage supports back-pressure, branch/jump redirect with flush, and halts cleanly once the PC runs past the end of the loaded program.

## Interface

Parameters:

- `PC_WIDTH`, 32, width of PC and addresses
- `RESET_PC`, 0, PC value loaded on reset
- `NUM_INSTRUCTIONS`, 11, program length in words; must match the `IMem` `numInstructions` value

Ports (clock and reset first):

- `i_clk`  in  1  single clock; all state updates on the rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `o_pc`  out  PC_WIDTH  fetch address to `IMem` `i_pc`; word index, not a byte address
- `i_instruction`  in  32  `IMem` `o_instruction`; combinational, valid in the same cycle as `o_pc`
- `i_redirect`  in  1  branch/jump taken; flushes the stage
- `i_redirect_pc`  in  PC_WIDTH  redirect target, word index
- `o_inst_valid`  out  1  IF/ID register holds a valid instruction
- `o_inst`  out  32  registered instruction
- `o_inst_pc`  out  PC_WIDTH  PC of `o_inst`
- `i_inst_ready`  in  1  decode accepts `o_inst` this cycle
- `o_halted`  out  1  FSM in HALT

## Operation

- FSM states: RUN and HALT. `o_halted` is 1 exactly when the state is HALT.
- Definitions:
  - `xfer` = `o_inst_valid && i_inst_ready`
  - `in_range` = `pc < NUM_INSTRUCTIONS`, compared unsigned
  - `load` = RUN && `in_range` && (!`o_inst_valid` || `i_inst_ready`) && !`i_redirect`
- Priority at each edge is redirect, then load, then drain, then the halt transition.
- Redirect (`i_redirect` = 1), in any state:
  - pc <= `i_redirect_pc`; `o_inst_valid` <= 0; state <= RUN.
  - A simultaneous `xfer` still counts as consumed by decode.
- Load:
  - `o_inst` <= `i_instruction`; `o_inst_pc` <= pc; `o_inst_valid` <= 1.
  - pc <= pc + 1, modulo 2^PC_WIDTH (wraps, no saturation).
- Drain: if there is no load and `xfer` is 1, `o_inst_valid` <= 0.
- Halt transition: RUN && !`in_range` && !`i_redirect` → HALT. The pc holds.
- In HALT:
  - pc is frozen and no loads occur.
  - The output register still drains normally on `xfer`.
  - Only a redirect or reset leaves HALT.
- A redirect to an out-of-range target enters RUN, then HALT on the following edge. No instruction is loaded in between.
- Stall (`o_inst_valid` && !`i_inst_ready`): `o_inst`, `o_inst_pc` and pc all hold.
- `o_pc` is combinationally equal to the pc register.

## Timing

- Reset (`i_rst_n` low) forces the following immediately, without waiting for a clock edge:
  - pc = `RESET_PC`, so `o_pc` = `RESET_PC`
  - `o_inst_valid` = 0, `o_inst` = 0, `o_inst_pc` = 0
  - state = RUN, `o_halted` = 0
- First rising edge after reset release: `o_inst_valid` = 1 with `o_inst_pc` = `RESET_PC` (when `RESET_PC` < `NUM_INSTRUCTIONS`).
- Load latency: 1 edge from `o_pc` presentation to `o_inst` valid.
- Throughput: 1 instruction/cycle while `i_inst_ready` is held high.
- Redirect latency:
  - Edge 1: `o_inst_valid` = 0 and `o_pc` = target.
  - Edge 2: `o_inst_pc` = target.
- End of program: the edge that loads pc = `NUM_INSTRUCTIONS`−1 is followed by one edge that sets `o_halted` = 1.
- Reset asserted mid-operation discards any pending instruction, including while stalled.

## Test plan

Default parameters; `IMem` loaded with the `rtest.o` image; compare against `mem[k]`.

1. **Async reset:** assert `i_rst_n` = 0 mid-cycle while streaming → `o_pc` = 0, `o_inst_valid` = 0, `o_halted` = 0 before the next edge.
2. **Streaming:** `i_inst_ready` = 1 from release → edges 1..11 give `o_inst_pc` 0..10 with `o_inst` = `mem[k]`. Edge 12: `o_halted` = 1 and `o_inst_valid` = 0. `o_pc` stays 11 thereafter.
3. **Back-pressure:** drop `i_inst_ready` when `o_inst_pc` = 3 and hold low for 3 cycles → `o_inst_pc` = 3, `o_inst` = `mem[3]`, `o_pc` = 4 throughout. Re-raise → next edge `o_inst_pc` = 4.
4. **Redirect mid-stream:** pulse `i_redirect` with target 7 while `o_inst_pc` = 2, `i_inst_ready` = 1 → next edge `o_inst_valid` = 0, `o_pc` = 7. Following edge `o_inst_pc` = 7, `o_inst` = `mem[7]`.
5. **Redirect from HALT:**
   - Target 2 → `o_halted` = 0 after 1 edge; `o_inst_pc` = 2 one edge later.
   - Then target 20 → RUN for 1 edge, then `o_halted` = 1, with `o_inst_valid` never 1 for pc 20.
6. **Redirect during stall:** `o_inst_valid` = 1, `i_inst_ready` = 0, redirect to 5 → stalled instruction dropped (`o_inst_valid` = 0). Next edge `o_inst_pc` = 5.
